// File: rtl/bcd_tick_counter.sv
// Prescaled packed-BCD counter with programmable modulo, up/down, clear and load.
// Emits one-cycle tick/wrap strobes aligned with each new count value.
module bcd_tick_counter #(
    parameter int unsigned PRESCALE = 50,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned MODULO   = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  tick,
    output logic                  wrap
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i+:4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0]  MAX_BCD = to_bcd(MODULO - 1);
    localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (c) begin
                if (v[4*i+:4] == 4'd9) begin
                    r[4*i+:4] = 4'd0;
                end else begin
                    r[4*i+:4] = v[4*i+:4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (b) begin
                if (v[4*i+:4] == 4'd0) begin
                    r[4*i+:4] = 4'd9;
                end else begin
                    r[4*i+:4] = v[4*i+:4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // With all nibbles <= 9, packed BCD orders the same as its decimal value.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i+:4] > 4'd9) ok = 1'b0;
        end
        if (v > MAX_BCD) ok = 1'b0;
        return ok;
    endfunction

    logic [PW-1:0] pc;
    logic [W-1:0]  step_val;
    logic          step_wrap;
    logic [W-1:0]  load_safe;

    always_comb begin
        step_val  = '0;
        step_wrap = 1'b0;
        if (up) begin
            if (bcd_out == MAX_BCD) begin
                step_val  = '0;
                step_wrap = 1'b1;
            end else begin
                step_val = bcd_inc(bcd_out);
            end
        end else begin
            if (bcd_out == '0) begin
                step_val  = MAX_BCD;
                step_wrap = 1'b1;
            end else begin
                step_val = bcd_dec(bcd_out);
            end
        end
    end

    assign load_safe = bcd_valid(load_val) ? load_val : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= '0;
            bcd_out <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (clr) begin
                pc      <= '0;
                bcd_out <= '0;
            end else if (load) begin
                pc      <= '0;
                bcd_out <= load_safe;
            end else if (en) begin
                if (pc == PC_LAST) begin
                    pc      <= '0;
                    bcd_out <= step_val;
                    tick    <= 1'b1;
                    wrap    <= step_wrap;
                end else begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

endmodule
